// File: rtl/ifetch_queue.sv
// Instruction fetch front end. Requests are limited by a credit count, responses
// go into an in-order queue, and a redirect discards stale responses.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic [5:0]  instr_op_o,
    input  logic        instr_ready_i,
    output logic        dbg_drain_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;
    state_e state_q, state_d;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      mem_pc_q    [DEPTH];
    logic [31:0]      mem_instr_q [DEPTH];

    logic           grant;
    logic           push;
    logic           pop;
    logic [CNT_W:0] credit_used;
    logic [31:0]    redirect_pc_al;
    logic           unused_redirect_lsbs;

    assign redirect_pc_al       = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Queued plus outstanding words never exceed DEPTH, so a response always has a slot.
    assign credit_used = {1'b0, occ_q} + {1'b0, inflight_q};
    assign imem_req_o  = !rst_i && !redirect_i && (credit_used < {1'b0, DEPTH_C});
    assign imem_addr_o = pc_q;
    assign grant       = imem_req_o && imem_gnt_i;
    assign push        = imem_rvalid_i && !redirect_i && (state_q == RUN);

    assign instr_valid_o = !rst_i && (occ_q != '0);
    assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
    assign instr_o       = instr_valid_o ? mem_instr_q[rd_ptr_q] : 32'h0;
    assign instr_pc_o    = instr_valid_o ? mem_pc_q[rd_ptr_q] : 32'h0;
    assign instr_op_o    = instr_o[31:26];
    assign dbg_drain_o   = (state_q == DRAIN);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        occ_d      = occ_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (grant) begin
            pc_d = pc_q + 32'd4;
        end
        case ({grant, imem_rvalid_i})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        if (redirect_i) begin
            // Everything still outstanding after this cycle belongs to a dead stream.
            pc_d      = redirect_pc_al;
            resp_pc_d = redirect_pc_al;
            discard_d = inflight_d;
            occ_d     = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            state_d   = (inflight_d != '0) ? DRAIN : RUN;
        end else begin
            if ((state_q == DRAIN) && imem_rvalid_i) begin
                discard_d = discard_q - CNT_W'(1);
                if (discard_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + CNT_W'(1);
                2'b01:   occ_d = occ_q - CNT_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            resp_pc_q  <= {RESET_PC[31:2], 2'b00};
            inflight_q <= '0;
            discard_q  <= '0;
            occ_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= resp_pc_q;
            mem_instr_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

    push_not_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && (occ_q == DEPTH_C)));

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a 1-cycle in-order memory model, an expected-pc
// queue checked on every accepted instruction, and hand-computed per-cycle checks.
module tb_ifetch_queue;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [5:0]  instr_op_o;
    logic        instr_ready_i;
    logic        dbg_drain_o;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_op_o    (instr_op_o),
        .instr_ready_i (instr_ready_i),
        .dbg_drain_o   (dbg_drain_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    int          grants = 0;
    logic [31:0] mem_q[$];
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, then update the memory model.
    task automatic step(input logic rst, input logic gnt, input logic rdy, input logic redir,
                        input logic [31:0] rpc, input logic resp_en);
        logic [31:0] e;
        logic [5:0]  e_op;
        @(negedge clk_i);
        rst_i         = rst;
        imem_gnt_i    = gnt;
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        if (!rst && resp_en && (mem_q.size() != 0)) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = ~mem_q[0];
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
        #1;
        if (!rst && !redir && instr_valid_o && instr_ready_i) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pc", instr_pc_o, 32'hFFFF_FFFF);
            end else begin
                e    = exp_q.pop_front();
                e_op = ~e[31:26];
                check("sb_pc", instr_pc_o, e);
                check("sb_instr", instr_o, ~e);
                check("sb_op", {26'd0, instr_op_o}, {26'd0, e_op});
            end
        end
        if (rst) begin
            mem_q.delete();
        end else begin
            if (imem_rvalid_i) void'(mem_q.pop_front());
            if (imem_req_o && imem_gnt_i) begin
                mem_q.push_back(imem_addr_o);
                grants++;
            end
        end
    endtask

    task automatic cyc(input logic gnt, input logic rdy, input logic redir,
                       input logic [31:0] rpc, input logic resp_en);
        step(1'b0, gnt, rdy, redir, rpc, resp_en);
    endtask

    task automatic do_reset(input logic redir, input logic [31:0] rpc);
        check("sb_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        step(1'b1, 1'b1, 1'b0, redir, rpc, 1'b0);
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", instr_pc_o, 32'd0);
        step(1'b1, 1'b1, 1'b0, redir, rpc, 1'b0);
        check("rst_state", {31'd0, dbg_drain_o}, 32'd0);
        check("rst_req2", {31'd0, imem_req_o}, 32'd0);
    endtask

    initial begin
        rst_i         = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;

        // Streaming fetch, then a 3-cycle grant stall at 0x10.
        do_reset(1'b0, 32'h0);
        exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);  exp_q.push_back(32'h10);
        cyc(1, 1, 0, 0, 1);
        check("s1_first_req", {31'd0, imem_req_o}, 32'd1);
        check("s1_addr0", imem_addr_o, 32'h0);
        check("s1_valid0", {31'd0, instr_valid_o}, 32'd0);
        cyc(1, 1, 0, 0, 1);
        check("s1_addr1", imem_addr_o, 32'h4);
        check("s1_valid1", {31'd0, instr_valid_o}, 32'd0);
        cyc(1, 1, 0, 0, 1);
        check("s1_addr2", imem_addr_o, 32'h8);
        check("s1_valid2", {31'd0, instr_valid_o}, 32'd1);
        check("s1_pc2", instr_pc_o, 32'h0);
        cyc(1, 1, 0, 0, 1);
        check("s1_addr3", imem_addr_o, 32'hC);
        check("s1_pc3", instr_pc_o, 32'h4);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 1);
            check("s3_stall_addr", imem_addr_o, 32'h10);
            check("s3_stall_req", {31'd0, imem_req_o}, 32'd1);
        end
        check("s3_drained", {31'd0, instr_valid_o}, 32'd0);
        cyc(1, 1, 0, 0, 1);
        check("s3_grant_addr", imem_addr_o, 32'h10);
        cyc(1, 1, 0, 0, 1);
        check("s3_next_addr", imem_addr_o, 32'h14);
        cyc(1, 1, 0, 0, 1);

        // Back-pressure: exactly DEPTH grants, then one request per pop.
        do_reset(1'b0, 32'h0);
        exp_q.push_back(32'h0);  exp_q.push_back(32'h4);
        grants = 0;
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 1);
        check("s2_grants", 32'(grants), 32'd4);
        check("s2_req_full", {31'd0, imem_req_o}, 32'd0);
        check("s2_head_pc", instr_pc_o, 32'h0);
        check("s2_head_op", {26'd0, instr_op_o}, 32'h3F);
        cyc(1, 1, 0, 0, 1);
        check("s2_req_pop0", {31'd0, imem_req_o}, 32'd0);
        cyc(1, 1, 0, 0, 1);
        check("s2_req_resume", {31'd0, imem_req_o}, 32'd1);
        check("s2_resume_addr", imem_addr_o, 32'h10);

        // Redirect with 2 in flight and 1 queued.
        do_reset(1'b0, 32'h0);
        exp_q.push_back(32'h100);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h0000_0103, 0);
        check("s4_redir_req", {31'd0, imem_req_o}, 32'd0);
        cyc(1, 0, 0, 0, 1);
        check("s4_valid_after", {31'd0, instr_valid_o}, 32'd0);
        check("s4_drain", {31'd0, dbg_drain_o}, 32'd1);
        check("s4_new_addr", imem_addr_o, 32'h100);
        cyc(1, 0, 0, 0, 1);
        check("s4_drain2", {31'd0, dbg_drain_o}, 32'd1);
        check("s4_addr2", imem_addr_o, 32'h104);
        check("s4_valid2", {31'd0, instr_valid_o}, 32'd0);
        cyc(1, 1, 0, 0, 1);
        check("s4_run", {31'd0, dbg_drain_o}, 32'd0);
        check("s4_valid3", {31'd0, instr_valid_o}, 32'd0);
        cyc(1, 1, 0, 0, 1);
        check("s4_first_pc", instr_pc_o, 32'h100);

        // Second redirect during DRAIN with a simultaneous response.
        do_reset(1'b0, 32'h0);
        exp_q.push_back(32'h200);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h0000_0103, 0);
        cyc(1, 0, 0, 0, 1);
        check("s5_drain", {31'd0, dbg_drain_o}, 32'd1);
        cyc(1, 0, 1, 32'h0000_0200, 1);
        check("s5_redir_req", {31'd0, imem_req_o}, 32'd0);
        cyc(1, 1, 0, 0, 1);
        check("s5_still_drain", {31'd0, dbg_drain_o}, 32'd1);
        check("s5_valid", {31'd0, instr_valid_o}, 32'd0);
        check("s5_addr", imem_addr_o, 32'h200);
        cyc(1, 1, 0, 0, 1);
        check("s5_run", {31'd0, dbg_drain_o}, 32'd0);
        check("s5_valid2", {31'd0, instr_valid_o}, 32'd0);
        cyc(1, 1, 0, 0, 1);
        check("s5_first_pc", instr_pc_o, 32'h200);

        // Reset beats redirect; unaligned redirect target; PC wrap.
        do_reset(1'b1, 32'h0000_0300);
        exp_q.push_back(32'hFFFF_FFFC);
        cyc(0, 1, 0, 0, 1);
        check("s6_rst_addr", imem_addr_o, 32'h0);
        check("s6_rst_req", {31'd0, imem_req_o}, 32'd1);
        cyc(0, 1, 1, 32'hFFFF_FFFF, 1);
        check("s6_redir_req", {31'd0, imem_req_o}, 32'd0);
        cyc(1, 1, 0, 0, 1);
        check("s6_no_drain", {31'd0, dbg_drain_o}, 32'd0);
        check("s6_top_addr", imem_addr_o, 32'hFFFF_FFFC);
        cyc(1, 1, 0, 0, 1);
        check("s6_wrap_addr", imem_addr_o, 32'h0);
        cyc(0, 1, 0, 0, 1);
        check("s6_after_wrap", imem_addr_o, 32'h4);

        check("sb_left", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
